// File: rtl/thread_scoreboard_if.sv
// ---------------------------------------------------------------------------
// thread_scoreboard_if
//   Bundles the scheduler-side issue channel, the writeback channel and the
//   scoreboard status outputs for thread_scoreboard.
//
//   master : the scheduler / completion side (drives issue_* and wb_*)
//   slave  : the scoreboard (drives issue_accept, busy_threads, the pulses)
//
//   issue_valid/issue_warp/issue_mask/issue_latency : issue request
//   issue_accept                                    : issue taken this cycle
//   wb_valid/wb_warp/wb_mask                        : writeback / completion
//   busy_threads                                    : registered busy vector
//   conflict_err / stray_wb                         : one-cycle error pulses
// ---------------------------------------------------------------------------
interface thread_scoreboard_if #(
    parameter int NUM_THREADS      = 32,
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 8,
    parameter int LAT_W            = 4
);
    localparam int WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int MASK_W = THREADS_PER_WARP / 2;

    logic                   issue_valid;
    logic [WARP_W-1:0]      issue_warp;
    logic [MASK_W-1:0]      issue_mask;
    logic [LAT_W-1:0]       issue_latency;
    logic                   issue_accept;
    logic                   wb_valid;
    logic [WARP_W-1:0]      wb_warp;
    logic [MASK_W-1:0]      wb_mask;
    logic [NUM_THREADS-1:0] busy_threads;
    logic                   conflict_err;
    logic                   stray_wb;

    modport master (
        output issue_valid, issue_warp, issue_mask, issue_latency,
        output wb_valid, wb_warp, wb_mask,
        input  issue_accept, busy_threads, conflict_err, stray_wb
    );

    modport slave (
        input  issue_valid, issue_warp, issue_mask, issue_latency,
        input  wb_valid, wb_warp, wb_mask,
        output issue_accept, busy_threads, conflict_err, stray_wb
    );
endinterface

// File: rtl/thread_scoreboard.sv
// ---------------------------------------------------------------------------
// thread_scoreboard
//   Tracks which threads have an instruction in flight. An accepted issue
//   marks the selected threads busy and loads a per-thread latency counter;
//   a thread clears when its counter runs out (latency >= 1) or when a
//   writeback covers it (any latency, including 0 = hold until writeback).
//   Issues that touch an already-busy thread are rejected.
//
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   sb       : thread_scoreboard_if.slave (issue, writeback, status)
// ---------------------------------------------------------------------------
module thread_scoreboard #(
    parameter int NUM_THREADS      = 32,
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 8,
    parameter int LAT_W            = 4
) (
    input  logic                clk,
    input  logic                rst,
    thread_scoreboard_if.slave  sb
);
    localparam int WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int MASK_W = THREADS_PER_WARP / 2;

    logic [NUM_THREADS-1:0] busy_q;
    logic [LAT_W-1:0]       cnt_q [NUM_THREADS];
    logic                   conflict_q;
    logic                   stray_q;

    logic [NUM_THREADS-1:0] t_issue;
    logic [NUM_THREADS-1:0] t_wb;
    logic                   mask_nz;
    logic                   overlap;
    logic                   accept;

    // Each mask bit covers a pair of adjacent threads; the warp's 8-thread
    // group is then placed at its slot in the global vector.
    function automatic logic [NUM_THREADS-1:0] expand(
        input logic [MASK_W-1:0] m,
        input logic [WARP_W-1:0] w
    );
        logic [NUM_THREADS-1:0] v;
        v = '0;
        for (int k = 0; k < MASK_W; k++) begin
            v[2*k]   = m[k];
            v[2*k+1] = m[k];
        end
        return v << (int'(w) * THREADS_PER_WARP);
    endfunction

    // Overlap is judged against the registered state only, so a thread that
    // is clearing on this very edge still blocks a new issue.
    always_comb begin
        t_issue = expand(sb.issue_mask, sb.issue_warp);
        t_wb    = sb.wb_valid ? expand(sb.wb_mask, sb.wb_warp) : '0;
        mask_nz = |sb.issue_mask;
        overlap = |(t_issue & busy_q);
        accept  = sb.issue_valid & mask_nz & ~overlap;
    end

    assign sb.issue_accept = accept;
    assign sb.busy_threads = busy_q;
    assign sb.conflict_err = conflict_q;
    assign sb.stray_wb     = stray_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
            stray_q    <= 1'b0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            conflict_q <= sb.issue_valid & mask_nz & overlap;
            stray_q    <= |(t_wb & ~busy_q);
            for (int i = 0; i < NUM_THREADS; i++) begin
                // An accepted issue only ever targets idle threads, so it
                // wins over a (stray) writeback naming the same thread.
                if (accept && t_issue[i]) begin
                    busy_q[i] <= 1'b1;
                    cnt_q[i]  <= sb.issue_latency;
                end else if (t_wb[i]) begin
                    busy_q[i] <= 1'b0;
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] == LAT_W'(1)) begin
                    busy_q[i] <= 1'b0;
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i]  <= cnt_q[i] - LAT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_thread_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_thread_scoreboard
//   Directed scenarios followed by randomized traffic. The reference model
//   records, per thread, the cycle at which it stops being busy (or that it
//   waits for a writeback) and derives every expected output from that.
// ---------------------------------------------------------------------------
module tb_thread_scoreboard;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: busy while cyc < exp_t[i], or while hold[i]
    int cyc = 0;
    int exp_t [32];
    bit hold  [32];

    thread_scoreboard_if sbif ();

    thread_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit in_set(input logic [3:0] m, input logic [1:0] w, input int i);
        return ((i / 8) == int'(w)) && m[(i % 8) / 2];
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = hold[i] || (cyc < exp_t[i]);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            exp_t[i] = 0;
            hold[i]  = 1'b0;
        end
    endtask

    task automatic drive(input bit iv, input logic [1:0] iw, input logic [3:0] im,
                         input logic [3:0] il, input bit wv, input logic [1:0] ww,
                         input logic [3:0] wm);
        sbif.issue_valid   = iv;
        sbif.issue_warp    = iw;
        sbif.issue_mask    = im;
        sbif.issue_latency = il;
        sbif.wb_valid      = wv;
        sbif.wb_warp       = ww;
        sbif.wb_mask       = wm;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0);
    endtask

    // One clock: check issue_accept before the edge, advance the model,
    // then check the registered outputs after the edge.
    task automatic step(input string tag);
        logic [31:0] bm;
        bit ovl, stray_e, any_i, acc_e, conf_e, iv, wv;
        logic [1:0] iw, ww;
        logic [3:0] im, wm, il;
        #1;
        iv = sbif.issue_valid; iw = sbif.issue_warp; im = sbif.issue_mask;
        il = sbif.issue_latency;
        wv = sbif.wb_valid; ww = sbif.wb_warp; wm = sbif.wb_mask;
        bm = model_busy();
        ovl = 1'b0;
        stray_e = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (in_set(im, iw, i) && bm[i]) ovl = 1'b1;
            if (wv && in_set(wm, ww, i) && !bm[i]) stray_e = 1'b1;
        end
        any_i  = iv && (im != 4'd0);
        acc_e  = any_i && !ovl;
        conf_e = any_i && ovl;
        chk({tag, ".accept"}, 64'(sbif.issue_accept), 64'(acc_e));
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 32; i++) begin
            if (acc_e && in_set(im, iw, i)) begin
                exp_t[i] = cyc + int'(il);
                hold[i]  = (il == 4'd0);
            end else if (wv && in_set(wm, ww, i)) begin
                exp_t[i] = 0;
                hold[i]  = 1'b0;
            end
        end
        #1;
        chk({tag, ".busy"},     64'(sbif.busy_threads), 64'(model_busy()));
        chk({tag, ".conflict"}, 64'(sbif.conflict_err), 64'(conf_e));
        chk({tag, ".stray"},    64'(sbif.stray_wb),     64'(stray_e));
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b1;
        #1;
        chk("reset.busy",     64'(sbif.busy_threads), 64'h0);
        chk("reset.conflict", 64'(sbif.conflict_err), 64'h0);
        chk("reset.stray",    64'(sbif.stray_wb),     64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // warp1 pairs 0,1 with latency 3: busy for exactly three cycles
        drive(1'b1, 2'd1, 4'b0011, 4'd3, 1'b0, 2'd0, 4'd0);
        step("lat3.issue");
        chk("lat3.busy_c1", 64'(sbif.busy_threads), 64'h0000_0F00);
        idle();
        step("lat3.c2");
        step("lat3.c3");
        chk("lat3.busy_c3", 64'(sbif.busy_threads), 64'h0000_0F00);
        step("lat3.clear");
        chk("lat3.busy_end", 64'(sbif.busy_threads), 64'h0);

        // latency 0 holds until writeback
        drive(1'b1, 2'd0, 4'b0001, 4'd0, 1'b0, 2'd0, 4'd0);
        step("hold.issue");
        idle();
        for (int k = 0; k < 10; k++) step("hold.wait");
        chk("hold.busy10", 64'(sbif.busy_threads[1:0]), 64'h3);
        drive(1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd0, 4'b0001);
        step("hold.wb");
        chk("hold.cleared", 64'(sbif.busy_threads), 64'h0);
        chk("hold.nostray", 64'(sbif.stray_wb), 64'h0);

        // conflicting issue on warp2
        drive(1'b1, 2'd2, 4'b1000, 4'd0, 1'b0, 2'd0, 4'd0);
        step("conf.setup");
        drive(1'b1, 2'd2, 4'b1100, 4'd5, 1'b0, 2'd0, 4'd0);
        step("conf.reject");
        chk("conf.pulse", 64'(sbif.conflict_err), 64'h1);
        chk("conf.busy",  64'(sbif.busy_threads), 64'h00C0_0000);
        idle();
        step("conf.after");
        chk("conf.pulse_end", 64'(sbif.conflict_err), 64'h0);

        // issue to warp3 together with a stray writeback to idle warp0
        drive(1'b1, 2'd3, 4'b0001, 4'd2, 1'b1, 2'd0, 4'b1111);
        step("mix.both");
        chk("mix.busy",  64'(sbif.busy_threads), 64'h03C0_0000);
        chk("mix.stray", 64'(sbif.stray_wb), 64'h1);
        drive(1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 2'd2, 4'b1000);
        step("mix.clear_w2");
        idle();
        step("mix.drain");
        chk("mix.empty", 64'(sbif.busy_threads), 64'h0);

        // asynchronous reset in the middle of a long latency
        drive(1'b1, 2'd1, 4'b1111, 4'd15, 1'b0, 2'd0, 4'd0);
        step("arst.issue");
        idle();
        for (int k = 0; k < 4; k++) step("arst.wait");
        chk("arst.busy_pre", 64'(sbif.busy_threads), 64'h0000_FF00);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.busy_now", 64'(sbif.busy_threads), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 2'd1, 4'b1111, 4'd1, 1'b0, 2'd0, 4'd0);
        step("arst.reissue");
        chk("arst.accepted", 64'(sbif.busy_threads), 64'h0000_FF00);
        idle();
        step("arst.drain");

        // timer expiry colliding with writeback and a blocked issue
        drive(1'b1, 2'd0, 4'b0001, 4'd2, 1'b0, 2'd0, 4'd0);
        step("coll.issue");
        idle();
        step("coll.mid");
        drive(1'b1, 2'd0, 4'b0001, 4'd3, 1'b1, 2'd0, 4'b0001);
        step("coll.edge");
        chk("coll.busy",     64'(sbif.busy_threads), 64'h0);
        chk("coll.nostray",  64'(sbif.stray_wb), 64'h0);
        chk("coll.conflict", 64'(sbif.conflict_err), 64'h1);

        // zero mask with issue_valid: silently ignored
        drive(1'b1, 2'd1, 4'b0000, 4'd4, 1'b0, 2'd0, 4'd0);
        step("zero.mask");
        chk("zero.noconf", 64'(sbif.conflict_err), 64'h0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
            step("rand");
        end
        idle();
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
